keypad_scanner: RTL and testbench



---
 rtl/calc_pkg.sv | 35 +++
 rtl/keypad_scanner_if.sv | 13 +
 rtl/row_sync.sv | 25 ++
 rtl/keypad_scanner.sv | 237 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the keypad scanner and the
// calculator's keypad interpreter.
package calc_pkg;

    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_COLS  = 5;
    localparam int unsigned KEYCODE_W = 5;
    localparam int unsigned NUM_KEYS  = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} scan_state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_t;

    // Keycode = col*4 + row; hex digits first, then operators and equals.
    localparam logic [KEYCODE_W-1:0] KEY_0      = 5'd0;
    localparam logic [KEYCODE_W-1:0] KEY_1      = 5'd1;
    localparam logic [KEYCODE_W-1:0] KEY_2      = 5'd2;
    localparam logic [KEYCODE_W-1:0] KEY_3      = 5'd3;
    localparam logic [KEYCODE_W-1:0] KEY_4      = 5'd4;
    localparam logic [KEYCODE_W-1:0] KEY_5      = 5'd5;
    localparam logic [KEYCODE_W-1:0] KEY_6      = 5'd6;
    localparam logic [KEYCODE_W-1:0] KEY_7      = 5'd7;
    localparam logic [KEYCODE_W-1:0] KEY_8      = 5'd8;
    localparam logic [KEYCODE_W-1:0] KEY_9      = 5'd9;
    localparam logic [KEYCODE_W-1:0] KEY_A      = 5'd10;
    localparam logic [KEYCODE_W-1:0] KEY_B      = 5'd11;
    localparam logic [KEYCODE_W-1:0] KEY_C      = 5'd12;
    localparam logic [KEYCODE_W-1:0] KEY_D      = 5'd13;
    localparam logic [KEYCODE_W-1:0] KEY_E      = 5'd14;
    localparam logic [KEYCODE_W-1:0] KEY_F      = 5'd15;
    localparam logic [KEYCODE_W-1:0] KEY_OP_ADD = 5'd16;
    localparam logic [KEYCODE_W-1:0] KEY_OP_SUB = 5'd17;
    localparam logic [KEYCODE_W-1:0] KEY_OP_MUL = 5'd18;
    localparam logic [KEYCODE_W-1:0] KEY_EQ     = 5'd19;

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: accepted-key interface from the scanner (master) to the
// calculator top (slave).
interface keypad_scanner_if;
    import calc_pkg::*;

    logic                 newkey;
    logic [KEYCODE_W-1:0] keycode;
    logic                 keydown;

    modport master (output newkey, keycode, keydown);
    modport slave  (input  newkey, keycode, keydown);

endinterface

// File: rtl/row_sync.sv
// row_sync: two-flop synchroniser for asynchronous, idle-high inputs.
// Resets to all-ones so a pulled-up bus reads as "nothing closed".
module row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; reset forces the idle-high level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x5 key matrix one column at a time, classifies each
// full frame, debounces presses and releases, and emits newkey/keycode/keydown.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat pulses while a key
// is held; without it, exactly one newkey pulse is produced per press.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows_n,
    output logic [NUM_COLS-1:0] cols_n,
    keypad_scanner_if.master    key
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    // The synchroniser needs at least three cycles per column to settle.
    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    logic [DIV_W-1:0]             div_q;
    logic [2:0]                   col_q;
    logic [NUM_ROWS-1:0]          rows_s;
    logic [NUM_KEYS-NUM_ROWS-1:0] acc_q;
    logic                         frame_end;

    logic [NUM_KEYS-1:0]  closed;
    logic [1:0]           hits;
    logic [KEYCODE_W-1:0] hit_code;
    frame_res_t           res;

    scan_state_t          state_q, state_d;
    logic [KEYCODE_W-1:0] cand_q, cand_d, code_q, code_d, acc_code;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 newkey_q, newkey_d, keydown_q, keydown_d, accept;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_target;
    logic             rpt_en_q, rpt_en_d, rpt_first_q, rpt_first_d;
`endif

    row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (rows_n),
        .q     (rows_s)
    );

    assign cols_n    = ~(NUM_COLS'(1) << col_q);
    assign frame_end = (col_q == 3'(NUM_COLS - 1)) && (div_q == DIV_W'(SCAN_DIV - 1));

    // Column timing; closed contacts of columns 0..3 shift in so col0 ends up in the low nibble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            col_q <= '0;
            acc_q <= '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q <= '0;
            if (col_q == 3'(NUM_COLS - 1)) begin
                col_q <= '0;
            end else begin
                col_q <= col_q + 3'd1;
                acc_q <= {~rows_s, acc_q[NUM_KEYS-NUM_ROWS-1:NUM_ROWS]};
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Classify the frame: closed-contact count (saturating at 2) and lowest closed code.
    always_comb begin
        closed   = {~rows_s, acc_q};
        hits     = '0;
        hit_code = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (closed[i]) begin
                if (hits == 2'd0) hit_code = KEYCODE_W'(i);
                if (hits != 2'd2) hits = hits + 2'd1;
            end
        end
        case (hits)
            2'd0:    res = NONE;
            2'd1:    res = SINGLE;
            default: res = MULTI;
        endcase
    end

    // Debounce state machine and output next-state; only acts on frame ends.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        keydown_d = keydown_q;
        newkey_d  = 1'b0;
        accept    = 1'b0;
        acc_code  = cand_q;
        cnt_inc   = (cnt_q >= CNT_W'(DEBOUNCE_FRAMES)) ? cnt_q : cnt_q + 1'b1;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (res == SINGLE) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_FRAMES <= 1) begin
                            accept   = 1'b1;
                            acc_code = hit_code;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (res == SINGLE && hit_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) accept = 1'b1;
                    end else if (res == SINGLE) begin
                        cand_d = hit_code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (res == NONE) begin
                        if (DEBOUNCE_FRAMES <= 1) begin
                            keydown_d = 1'b0;
                            state_d   = IDLE;
                            cnt_d     = '0;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (res == NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                            keydown_d = 1'b0;
                            state_d   = IDLE;
                            cnt_d     = '0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (accept) begin
                code_d    = acc_code;
                newkey_d  = 1'b1;
                keydown_d = 1'b1;
                state_d   = HELD;
                cnt_d     = '0;
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_en_d    = rpt_en_q;
        rpt_first_d = rpt_first_q;
        rpt_inc     = (rpt_cnt_q >= RPT_W'(RPT_MAX)) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
        rpt_target  = rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
        if (frame_end) begin
            if (accept) begin
                rpt_cnt_d   = '0;
                rpt_en_d    = 1'b1;
                rpt_first_d = 1'b1;
            end else if (state_q == HELD && rpt_en_q) begin
                if (res == SINGLE && hit_code == code_q) begin
                    if (rpt_inc == rpt_target) begin
                        newkey_d    = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
                end else begin
                    rpt_en_d  = 1'b0;
                    rpt_cnt_d = '0;
                end
            end
        end
`endif
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            newkey_q  <= 1'b0;
            keydown_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            newkey_q  <= newkey_d;
            keydown_q <= keydown_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat frame counter, armed at each acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_cnt_q   <= '0;
            rpt_en_q    <= 1'b0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_en_q    <= rpt_en_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign key.newkey  = newkey_q;
    assign key.keycode = code_q;
    assign key.keydown = keydown_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level checks of keypad_scanner against a
// run-length reference model, plus directed reset and auto-repeat sequences.
module tb_keypad_scanner;
    import calc_pkg::*;

    localparam int unsigned D_FRAMES = 3;
    localparam int unsigned R_DELAY  = 8;
    localparam int unsigned R_RATE   = 4;
    localparam int unsigned FRAME    = 20;

    logic                clock;
    logic                reset;
    logic [NUM_ROWS-1:0] rows_n;
    logic [NUM_COLS-1:0] cols_n;
    logic [NUM_KEYS-1:0] keys;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (D_FRAMES),
        .REPEAT_DELAY    (R_DELAY),
        .REPEAT_RATE     (R_RATE)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .rows_n (rows_n),
        .cols_n (cols_n),
        .key    (kif)
    );

    // Passive matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        rows_n = '1;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (!cols_n[c] && keys[c*4 + r]) rows_n[r] = 1'b0;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    // Reference model: acceptance = D consecutive identical single-key frames while
    // not held; release = D consecutive empty frames while held.
    bit m_held, m_pulse, m_rpt_ok;
    int m_keycode, m_run_code, m_run, m_none_run, m_since;

    function automatic void model_reset();
        m_held = 0; m_pulse = 0; m_rpt_ok = 0;
        m_keycode = 0; m_run_code = 0; m_run = 0; m_none_run = 0; m_since = 0;
    endfunction

    function automatic void model_frame(input logic [NUM_KEYS-1:0] k);
        int n, c;
        n = $countones(k);
        c = 0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) if (k[i]) c = i;
        m_pulse = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && c == m_run_code) m_run++;
                else begin m_run_code = c; m_run = 1; end
            end else begin
                m_run = 0;
            end
            if (m_run >= int'(D_FRAMES)) begin
                m_held = 1; m_keycode = c; m_pulse = 1;
                m_run = 0; m_none_run = 0; m_rpt_ok = 1; m_since = 0;
            end
        end else begin
            if (n == 0) m_none_run++; else m_none_run = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_rpt_ok && n == 1 && c == m_keycode) begin
                m_since++;
                if (m_since >= int'(R_DELAY) && (m_since - int'(R_DELAY)) % int'(R_RATE) == 0) m_pulse = 1;
            end else begin
                m_rpt_ok = 0;
            end
`endif
            if (m_none_run >= int'(D_FRAMES)) begin
                m_held = 0; m_run = 0;
            end
        end
    endfunction

    bit          frame_pulse;
    int unsigned pulses;

    // Hold one key pattern for a whole frame, then compare the frame-end outputs.
    task automatic run_frame(input logic [NUM_KEYS-1:0] k);
        bit quiet;
        keys  = k;
        quiet = 1;
        for (int unsigned i = 1; i <= FRAME; i++) begin
            @(posedge clock);
            #1;
            if (i < FRAME && kif.newkey !== 1'b0) quiet = 0;
        end
        model_frame(k);
        check("newkey_quiet_midframe", 32'(quiet), 32'd1);
        check("newkey_frame_end", 32'(kif.newkey), 32'(m_pulse));
        check("keycode", 32'(kif.keycode), 32'(m_keycode));
        check("keydown", 32'(kif.keydown), 32'(m_held));
        frame_pulse = kif.newkey;
        if (frame_pulse) pulses++;
    endtask

    typedef struct {
        logic [NUM_KEYS-1:0]  keys;
        int unsigned          frames;
        bit                   alt;
        int unsigned          exp_pulses;
        logic [KEYCODE_W-1:0] exp_code;
        logic                 exp_down;
    } vec_t;

    localparam int unsigned NVEC = 9;

    initial begin : main
        vec_t                tbl[NVEC];
        logic [NUM_KEYS-1:0] rk;
        int unsigned         kind, len;
        int                  got[$];
        int                  exp_rep[$];

        tbl[0] = '{keys: 20'h00200, frames: 5,  alt: 0, exp_pulses: 1, exp_code: 5'd9,  exp_down: 1'b1};
        tbl[1] = '{keys: 20'h00000, frames: 2,  alt: 0, exp_pulses: 0, exp_code: 5'd9,  exp_down: 1'b1};
        tbl[2] = '{keys: 20'h00000, frames: 1,  alt: 0, exp_pulses: 0, exp_code: 5'd9,  exp_down: 1'b0};
        tbl[3] = '{keys: 20'h80000, frames: 3,  alt: 0, exp_pulses: 1, exp_code: 5'd19, exp_down: 1'b1};
        tbl[4] = '{keys: 20'h00000, frames: 3,  alt: 0, exp_pulses: 0, exp_code: 5'd19, exp_down: 1'b0};
        tbl[5] = '{keys: 20'h00040, frames: 12, alt: 1, exp_pulses: 0, exp_code: 5'd19, exp_down: 1'b0};
        tbl[6] = '{keys: 20'h00021, frames: 4,  alt: 0, exp_pulses: 0, exp_code: 5'd19, exp_down: 1'b0};
        tbl[7] = '{keys: 20'h00020, frames: 2,  alt: 0, exp_pulses: 0, exp_code: 5'd19, exp_down: 1'b0};
        tbl[8] = '{keys: 20'h00000, frames: 4,  alt: 0, exp_pulses: 0, exp_code: 5'd19, exp_down: 1'b0};

        reset = 1'b0;
        keys  = '0;
        model_reset();
        #1;
        check("reset_cols_n", 32'(cols_n), 32'b11110);
        check("reset_newkey", 32'(kif.newkey), 32'd0);
        check("reset_keycode", 32'(kif.keycode), 32'd0);
        check("reset_keydown", 32'(kif.keydown), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Directed frame-level vectors.
        for (int unsigned t = 0; t < NVEC; t++) begin
            pulses = 0;
            for (int unsigned f = 0; f < tbl[t].frames; f++)
                run_frame((tbl[t].alt && f[0]) ? '0 : tbl[t].keys);
            check($sformatf("vec%0d_pulses", t), pulses, tbl[t].exp_pulses);
            check($sformatf("vec%0d_keycode", t), 32'(kif.keycode), 32'(tbl[t].exp_code));
            check($sformatf("vec%0d_keydown", t), 32'(kif.keydown), 32'(tbl[t].exp_down));
        end

        // Random segments: none / single / two keys, each held for a random run of frames.
        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 99);
            len  = $urandom_range(1, 12);
            rk   = '0;
            if (kind >= 35 && kind < 85) begin
                rk[$urandom_range(0, NUM_KEYS - 1)] = 1'b1;
            end else if (kind >= 85) begin
                rk[$urandom_range(0, NUM_KEYS - 1)] = 1'b1;
                rk[$urandom_range(0, NUM_KEYS - 1)] = 1'b1;
            end
            for (int unsigned f = 0; f < len; f++) run_frame(rk);
        end
        for (int f = 0; f < 4; f++) run_frame('0);

        // Long hold of code 3: pulse frames relative to the start of the hold.
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_rep = '{3, 11, 15, 19, 23, 27};
`else
        exp_rep = '{3};
`endif
        for (int f = 1; f <= 30; f++) begin
            run_frame(20'h00008);
            if (frame_pulse) got.push_back(f);
        end
        check("hold_pulse_count", 32'(got.size()), 32'(exp_rep.size()));
        for (int i = 0; i < exp_rep.size() && i < got.size(); i++)
            check($sformatf("hold_pulse%0d_frame", i), 32'(got[i]), 32'(exp_rep[i]));
        check("hold_keycode", 32'(kif.keycode), 32'd3);

        // Reset dropped mid-frame with the key still held.
        repeat (7) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midreset_cols_n", 32'(cols_n), 32'b11110);
        check("midreset_newkey", 32'(kif.newkey), 32'd0);
        check("midreset_keycode", 32'(kif.keycode), 32'd0);
        check("midreset_keydown", 32'(kif.keydown), 32'd0);
        keys = '0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("post_reset_cols_n_c%0d", i), 32'(cols_n), (i < 4) ? 32'b11110 : 32'b11101);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
